// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath blocks.
// Holds the scan FSM state encoding and the default image and kernel sizes,
// which the MAC and line-buffer blocks also use.
package conv_pkg;

    localparam int unsigned DEF_K     = 3;
    localparam int unsigned DEF_IMG_W = 8;
    localparam int unsigned DEF_IMG_H = 8;
    localparam int unsigned DEF_AW    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/conv_scan_ctrl_if.sv
// Control/handshake bundle between the frame scan sequencer and its neighbours.
//   start, out_ready                      : frame control and downstream ready into the sequencer
//   busy, done                            : frame status out of the sequencer
//   pix_addr, mac_clr, mac_en             : pixel memory and MAC array controls
//   out_valid, out_row, out_col           : finished window coordinate
// The master modport is the sequencer side; slave is the surrounding logic.
interface conv_scan_ctrl_if #(
    parameter int unsigned AW = 8
);
    logic          start;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] pix_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          out_valid;
    logic [AW-1:0] out_row;
    logic [AW-1:0] out_col;

    modport master (
        input  start, out_ready,
        output busy, done, pix_addr, mac_clr, mac_en, out_valid, out_row, out_col
    );

    modport slave (
        output start, out_ready,
        input  busy, done, pix_addr, mac_clr, mac_en, out_valid, out_row, out_col
    );
endinterface

// File: rtl/window_index_counter.sv
// Two-level wrap counter (outer, inner). The inner index counts first; when it
// reaches INNER_MAX it wraps to 0 and the outer index advances (wrapping at
// OUTER_MAX). Used both for the in-window (i, j) walk and the (r, c) raster.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear of both indices (priority over en)
//   en         : advance by one step
//   outer/inner: current indices
//   last       : both indices at their maximum
module window_index_counter #(
    parameter int unsigned W         = 8,
    parameter int unsigned OUTER_MAX = 2,
    parameter int unsigned INNER_MAX = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] outer,
    output logic [W-1:0] inner,
    output logic         last
);

    logic inner_wrap;
    logic outer_wrap;

    assign inner_wrap = (inner == W'(INNER_MAX));
    assign outer_wrap = (outer == W'(OUTER_MAX));
    assign last       = inner_wrap && outer_wrap;

    // Index registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outer <= '0;
            inner <= '0;
        end else if (clr) begin
            outer <= '0;
            inner <= '0;
        end else if (en) begin
            if (inner_wrap) begin
                inner <= '0;
                outer <= outer_wrap ? '0 : outer + W'(1);
            end else begin
                inner <= inner + W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Frame sequencer for the 2-D convolution datapath. A start pulse walks every
// valid K x K window of the image in raster order: one CLEAR cycle, K*K ACCUM
// cycles issuing pixel addresses, then EMIT holding the window coordinate
// until the downstream accepts it. A one-cycle DONE ends the frame.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : conv_scan_ctrl_if master (start/out_ready in; status, pixel
//                address, MAC strobes and output coordinate out)
module conv_scan_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned K     = DEF_K,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic               clk,
    input  logic               reset,
    conv_scan_ctrl_if.master   bus
);

    state_t        state;
    state_t        state_nxt;

    logic          ij_clr;
    logic          ij_en;
    logic          ij_last;
    logic          rc_clr;
    logic          rc_en;
    logic          rc_last;
    logic [AW-1:0] i;
    logic [AW-1:0] j;
    logic [AW-1:0] r;
    logic [AW-1:0] c;

    // In-window (i, j) walk
    window_index_counter #(
        .W         (AW),
        .OUTER_MAX (K - 1),
        .INNER_MAX (K - 1)
    ) u_ij (
        .clk   (clk),
        .reset (reset),
        .clr   (ij_clr),
        .en    (ij_en),
        .outer (i),
        .inner (j),
        .last  (ij_last)
    );

    // Output raster (r, c) walk
    window_index_counter #(
        .W         (AW),
        .OUTER_MAX (IMG_H - K),
        .INNER_MAX (IMG_W - K)
    ) u_rc (
        .clk   (clk),
        .reset (reset),
        .clr   (rc_clr),
        .en    (rc_en),
        .outer (r),
        .inner (c),
        .last  (rc_last)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and counter control
    always_comb begin
        state_nxt = state;
        ij_clr    = 1'b0;
        ij_en     = 1'b0;
        rc_clr    = 1'b0;
        rc_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    rc_clr    = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                ij_clr    = 1'b1;
                state_nxt = ACCUM;
            end
            ACCUM: begin
                ij_en = 1'b1;
                if (ij_last) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (rc_last) begin
                        state_nxt = DONE;
                    end else begin
                        rc_en     = 1'b1;
                        state_nxt = CLEAR;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status and strobe registers, loaded with the decode of the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mac_clr   <= 1'b0;
            bus.mac_en    <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.busy      <= (state_nxt == CLEAR) || (state_nxt == ACCUM) || (state_nxt == EMIT);
            bus.done      <= (state_nxt == DONE);
            bus.mac_clr   <= (state_nxt == CLEAR);
            bus.mac_en    <= (state_nxt == ACCUM);
            bus.out_valid <= (state_nxt == EMIT);
        end
    end

    // Address and coordinate come straight from the counter registers
    assign bus.pix_addr = (r + i) * AW'(IMG_W) + (c + j);
    assign bus.out_row  = r;
    assign bus.out_col  = c;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Scoreboard bench for conv_scan_ctrl. Three instances: 4x4/K3 (main),
// 3x3/K3 and 2x2/K1. Stimulus pushes expected MAC events, output coordinates,
// done cycles and busy lengths; negedge monitors pop and compare.
module tb_conv_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   s0  = 0;
    int   checks = 0;
    int   errors = 0;

    int q_ev   [3][$];
    int q_row  [3][$];
    int q_col  [3][$];
    int q_done [3][$];
    int q_busy [3][$];
    int busy_cnt [3];

    int addr_tab [4][9] = '{
        '{0, 1, 2, 4, 5, 6, 8, 9, 10},
        '{1, 2, 3, 5, 6, 7, 9, 10, 11},
        '{4, 5, 6, 8, 9, 10, 12, 13, 14},
        '{5, 6, 7, 9, 10, 11, 13, 14, 15}
    };

    conv_scan_ctrl_if #(.AW(8)) ia ();
    conv_scan_ctrl_if #(.AW(8)) ib ();
    conv_scan_ctrl_if #(.AW(8)) ic ();

    conv_scan_ctrl #(.IMG_W(4), .IMG_H(4), .K(3), .AW(8)) u_a (.clk(clk), .reset(rst), .bus(ia));
    conv_scan_ctrl #(.IMG_W(3), .IMG_H(3), .K(3), .AW(8)) u_b (.clk(clk), .reset(rst), .bus(ib));
    conv_scan_ctrl #(.IMG_W(2), .IMG_H(2), .K(1), .AW(8)) u_c (.clk(clk), .reset(rst), .bus(ic));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void unexpected(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected value %0d, nothing expected (t=%0t)", name, act, $time);
    endfunction

    // One monitor step for instance id, sampled mid-cycle
    task automatic mon_step(input int id, input bit clr, input bit en, input int addr,
                            input bit ov, input bit ordy, input int row, input int col,
                            input bit busy, input bit done);
        int ev;
        if (busy) busy_cnt[id]++;
        if (clr || en) begin
            ev = clr ? -1 : addr;
            if (q_ev[id].size() == 0) unexpected($sformatf("d%0d_mac_event", id), ev);
            else chk($sformatf("d%0d_mac_event", id), ev, q_ev[id].pop_front());
        end
        if (ov) begin
            if (q_row[id].size() == 0) unexpected($sformatf("d%0d_out_valid", id), row);
            else if (ordy) begin
                chk($sformatf("d%0d_out_row", id), row, q_row[id].pop_front());
                chk($sformatf("d%0d_out_col", id), col, q_col[id].pop_front());
            end else begin
                chk($sformatf("d%0d_hold_row", id), row, q_row[id][0]);
                chk($sformatf("d%0d_hold_col", id), col, q_col[id][0]);
            end
        end
        if (done) begin
            if (q_done[id].size() == 0) unexpected($sformatf("d%0d_done", id), cyc - s0);
            else begin
                chk($sformatf("d%0d_done_cycle", id), cyc - s0, q_done[id].pop_front());
                chk($sformatf("d%0d_busy_cycles", id), busy_cnt[id], q_busy[id].pop_front());
            end
            busy_cnt[id] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = '{0, 0, 0};
        end else begin
            mon_step(0, ia.mac_clr, ia.mac_en, int'(ia.pix_addr), ia.out_valid, ia.out_ready,
                     int'(ia.out_row), int'(ia.out_col), ia.busy, ia.done);
            mon_step(1, ib.mac_clr, ib.mac_en, int'(ib.pix_addr), ib.out_valid, ib.out_ready,
                     int'(ib.out_row), int'(ib.out_col), ib.busy, ib.done);
            mon_step(2, ic.mac_clr, ic.mac_en, int'(ic.pix_addr), ic.out_valid, ic.out_ready,
                     int'(ic.out_row), int'(ic.out_col), ic.busy, ic.done);
        end
    end

    // Return just after the edge that opens cycle n of the current frame
    task automatic at_cycle(input int n);
        while (cyc - s0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_out(input int id, input int row, input int col);
        q_row[id].push_back(row);
        q_col[id].push_back(col);
    endtask

    // Full 4x4/K3 frame on instance 0
    task automatic push_frame_a(input int done_cyc, input int busy_len);
        for (int w = 0; w < 4; w++) begin
            q_ev[0].push_back(-1);
            for (int t = 0; t < 9; t++) q_ev[0].push_back(addr_tab[w][t]);
            push_out(0, w / 2, w % 2);
        end
        q_done[0].push_back(done_cyc);
        q_busy[0].push_back(busy_len);
    endtask

    task automatic check_a_zero(input string tag);
        chk({tag, "_busy"},      int'(ia.busy), 0);
        chk({tag, "_done"},      int'(ia.done), 0);
        chk({tag, "_mac_clr"},   int'(ia.mac_clr), 0);
        chk({tag, "_mac_en"},    int'(ia.mac_en), 0);
        chk({tag, "_out_valid"}, int'(ia.out_valid), 0);
        chk({tag, "_pix_addr"},  int'(ia.pix_addr), 0);
        chk({tag, "_out_row"},   int'(ia.out_row), 0);
        chk({tag, "_out_col"},   int'(ia.out_col), 0);
    endtask

    task automatic check_drained(input int id, input string tag);
        chk({tag, "_events_left"}, q_ev[id].size(), 0);
        chk({tag, "_outputs_left"}, q_row[id].size(), 0);
        chk({tag, "_done_left"}, q_done[id].size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ia.start = 1'b0; ia.out_ready = 1'b1;
        ib.start = 1'b0; ib.out_ready = 1'b1;
        ic.start = 1'b0; ic.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_a_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Frame 1: stray starts in cycle 7 and in the DONE cycle are ignored
        s0 = cyc;
        ia.start = 1'b1;
        push_frame_a(45, 44);
        at_cycle(1);  ia.start = 1'b0;
        at_cycle(7);  ia.start = 1'b1;
        at_cycle(8);  ia.start = 1'b0;
        at_cycle(45); ia.start = 1'b1;

        // Frame 2: start in the cycle after done, backpressure in first EMIT
        at_cycle(46);
        s0 = cyc;
        push_frame_a(50, 49);
        at_cycle(1);  ia.start = 1'b0;
        at_cycle(11); ia.out_ready = 1'b0;
        at_cycle(16); ia.out_ready = 1'b1;
        at_cycle(52);
        check_drained(0, "frame12");

        // Frame 3: reset in cycle 5 (ACCUM) discards the frame
        s0 = cyc;
        ia.start = 1'b1;
        q_ev[0].push_back(-1);
        q_ev[0].push_back(0);
        q_ev[0].push_back(1);
        q_ev[0].push_back(2);
        at_cycle(1);  ia.start = 1'b0;
        at_cycle(5);  rst = 1'b1;
        #1;
        check_a_zero("midreset");
        at_cycle(7);  rst = 1'b0;
        at_cycle(30);
        chk("after_reset_busy", int'(ia.busy), 0);
        check_drained(0, "frame3");

        // Frame 4: full frame after the aborted one
        s0 = cyc;
        ia.start = 1'b1;
        push_frame_a(45, 44);
        at_cycle(1);  ia.start = 1'b0;
        at_cycle(47);
        check_drained(0, "frame4");

        // Degenerate sizes: 3x3/K3 and 2x2/K1 started together
        s0 = cyc;
        ib.start = 1'b1;
        ic.start = 1'b1;
        q_ev[1].push_back(-1);
        for (int a = 0; a < 9; a++) q_ev[1].push_back(a);
        push_out(1, 0, 0);
        q_done[1].push_back(12);
        q_busy[1].push_back(11);
        for (int w = 0; w < 4; w++) begin
            q_ev[2].push_back(-1);
            q_ev[2].push_back(w);
            push_out(2, w / 2, w % 2);
        end
        q_done[2].push_back(13);
        q_busy[2].push_back(12);
        at_cycle(1);
        ib.start = 1'b0;
        ic.start = 1'b0;
        at_cycle(16);
        check_drained(1, "small3x3");
        check_drained(2, "k1_2x2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_scan_ctrl.md
# conv_scan_ctrl

Sequencer for the 2-D convolution datapath. On a `start` pulse it walks every valid K×K window of an IMG_W×IMG_H image in raster order, issuing pixel read addresses and MAC control strobes, then presents each finished output coordinate with a valid/ready handshake. It sits between the frame-level control logic and the pixel memory/MAC array, and replaces free-running ripple counting with a synchronous, fully sequenced scan.

## Interface
- `IMG_W`, default 8: image width in pixels; must be ≥ K.
- `IMG_H`, default 8: image height in pixels; must be ≥ K.
- `K`, default 3: kernel edge; must be ≥ 1.
- `AW`, default 8: address width; must satisfy 2^AW ≥ IMG_W·IMG_H.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `out_ready`  in  1  downstream accepts the current output.
- `busy`  out  1  high in CLEAR, ACCUM and EMIT.
- `done`  out  1  one-cycle pulse in DONE.
- `pix_addr`  out  AW  pixel read address; meaningful only while `mac_en` is high.
- `mac_clr`  out  1  clear the accumulator (CLEAR state).
- `mac_en`  out  1  accumulate the pixel at `pix_addr` (ACCUM state).
- `out_valid`  out  1  window result ready (EMIT state).
- `out_row`  out  AW  output row index r, 0..IMG_H−K.
- `out_col`  out  AW  output column index c, 0..IMG_W−K.

## Operation
- Reset value of every output is 0. Reset forces the FSM to IDLE and clears r, c, i and j. Reset takes effect immediately, including mid-frame; the partial frame is discarded and produces no `done`.
- FSM states: IDLE, CLEAR, ACCUM, EMIT, DONE. All outputs are registered or decoded from registered state. No output depends combinationally on an input.
- **IDLE:** on `start`, go to CLEAR with r = c = 0. Otherwise stay in IDLE.
- **CLEAR:** assert `mac_clr` for one cycle, set i = j = 0, go to ACCUM.
- **ACCUM:** runs for K·K cycles. Each cycle asserts `mac_en` with `pix_addr` = (r+i)·IMG_W + (c+j).
  - j increments first; it wraps to 0 and increments i when j = K−1.
  - At i = j = K−1, go to EMIT.
- **EMIT:** assert `out_valid`, with `out_row` = r and `out_col` = c. Stay in EMIT until `out_ready` is high. On the handshake:
  - if c < IMG_W−K: c+1, go to CLEAR;
  - else if r < IMG_H−K: c = 0, r+1, go to CLEAR;
  - else go to DONE.
- **DONE:** assert `done` for one cycle, go to IDLE.
- `start` is ignored outside IDLE, including in the DONE cycle.
- `out_row`, `out_col` and `out_valid` stay stable for the whole time `out_ready` is low.
- Address arithmetic is unsigned, AW bits wide. The parameter constraints guarantee it never overflows.

## Timing
- `start` sampled high at edge 0 gives CLEAR in cycle 1 and ACCUM in cycles 2..K²+1.
- With `out_ready` held high, each window costs K²+2 cycles.
- Frame length = (IMG_H−K+1)(IMG_W−K+1)(K²+2) cycles of `busy`, followed by one `done` cycle.
- Each cycle that `out_ready` is low in EMIT adds exactly one cycle to the frame.
- Earliest next `start` is accepted in the cycle after `done`.

## Structure
- Shared package `conv_pkg` holds:
  - the state enum (IDLE=0, CLEAR=1, ACCUM=2, EMIT=3, DONE=4, 3-bit encoding);
  - the default K/IMG_W/IMG_H constants, also used by the MAC and line-buffer blocks.
- One sub-module, `window_index_counter`:
  - a two-level (i, j) wrap counter with `clr`, `en` and `last` (i = j = K−1) outputs, async active-high reset;
  - the same module is reused for the (r, c) raster counter with its limits set to IMG_H−K and IMG_W−K.

## Test plan
- **Single frame (IMG_W = IMG_H = 4, K = 3):**
  - `start` at edge 0 with `out_ready` high → outputs (0,0), (0,1), (1,0), (1,1);
  - `busy` high in cycles 1–44, `done` in cycle 45.
- **Window addresses (same configuration):**
  - window (0,0) issues 0,1,2,4,5,6,8,9,10;
  - window (1,1) issues 5,6,7,9,10,11,13,14,15;
  - `mac_clr` occurs exactly once before each group of 9 `mac_en` cycles.
- **Backpressure:** `out_ready` low for 5 cycles in the first EMIT → `out_valid` is held and row/col stay at 0/0; `done` moves to cycle 50.
- **Ignored start:** `start` pulsed in cycle 7 and again in the DONE cycle → no restart and no extra outputs; a `start` one cycle after `done` begins a new frame.
- **Reset mid-frame:** `reset` asserted in cycle 5 (ACCUM) → all outputs are 0 immediately; after release, IDLE with no `done`; a following `start` produces a full correct frame.
- **Degenerate sizes:** IMG_W = IMG_H = K = 3 gives a single output (0,0) and `done` in cycle 12. K = 1 on a 2×2 image gives addresses 0,1,2,3, one per window.
